// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per cycle on a registered state.
// Optional abort port and abort path enabled by defining AES_INV_ROUND_CTRL_ABORT_EN.

module Inverse_shiftrow (
  input  logic [0:127] din,
  output logic [0:127] dout
);
  // Row r rotates right by r columns; byte index is row + 4*column.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dout[8*(r+4*c) +: 8] = din[8*(r+4*((c+4-r)%4)) +: 8];
    end
  end
endmodule

module inv_subbytes (
  input  logic [0:127] din,
  output logic [0:127] dout
);
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  for (genvar k = 0; k < 16; k++) begin : g_byte
    assign dout[8*k +: 8] = INV_SBOX[{din[8*k +: 8], 3'b000} +: 8];
  end
endmodule

module inv_mixcolumns (
  input  logic [0:127] din,
  output logic [0:127] dout
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {9*a, 11*a, 13*a, 14*a} in GF(2^8).
  function automatic logic [31:0] prods(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [31:0] p0, p1, p2, p3;
    assign p0 = prods(din[32*c      +: 8]);
    assign p1 = prods(din[32*c + 8  +: 8]);
    assign p2 = prods(din[32*c + 16 +: 8]);
    assign p3 = prods(din[32*c + 24 +: 8]);
    // Byte fields: [31:24]=9x, [23:16]=11x, [15:8]=13x, [7:0]=14x.
    assign dout[32*c      +: 8] = p0[7:0]   ^ p1[23:16] ^ p2[15:8]  ^ p3[31:24];
    assign dout[32*c + 8  +: 8] = p0[31:24] ^ p1[7:0]   ^ p2[23:16] ^ p3[15:8];
    assign dout[32*c + 16 +: 8] = p0[15:8]  ^ p1[31:24] ^ p2[7:0]   ^ p3[23:16];
    assign dout[32*c + 24 +: 8] = p0[23:16] ^ p1[15:8]  ^ p2[31:24] ^ p3[7:0];
  end
endmodule

module aes_inv_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic [3:0]   rk_idx,
  input  logic [0:127] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         st, st_n;
  logic [3:0]   rnd, rnd_n;
  logic [0:127] state, state_n;
  logic [0:127] sr, sb, ark, mc;

  Inverse_shiftrow u_isr (.din(state), .dout(sr));
  inv_subbytes     u_isb (.din(sr),    .dout(sb));
  assign ark = sb ^ rk_data;
  inv_mixcolumns   u_imc (.din(ark),   .dout(mc));

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      rnd   <= '0;
      state <= '0;
    end else begin
      st    <= st_n;
      rnd   <= rnd_n;
      state <= state_n;
    end
  end

  always_comb begin
    st_n    = st;
    rnd_n   = rnd;
    state_n = state;
    rk_idx  = 4'd10;
    unique case (st)
      IDLE: begin
        if (in_valid) begin
          state_n = in_data ^ rk_data;
          rnd_n   = 4'd9;
          st_n    = ROUND;
        end
      end
      ROUND: begin
        rk_idx  = rnd;
        state_n = mc;
        if (rnd == 4'd1) st_n = FINAL;
        else             rnd_n = rnd - 4'd1;
      end
      FINAL: begin
        rk_idx  = 4'd0;
        state_n = ark;
        st_n    = DONE;
      end
      DONE: begin
        if (out_ready) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
    if (abort && st != IDLE) begin
      st_n    = IDLE;
      state_n = '0;
    end
`endif
  end

  assign in_ready  = (st == IDLE) && !rst;
  assign out_valid = (st == DONE);
  assign out_data  = state;
  assign busy      = (st != IDLE);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Scoreboard bench: expected plaintexts come from a forward AES-128 model (S-box derived from GF(2^8) inverses).
module tb_aes_inv_round_ctrl;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, abort;
  logic         in_ready, out_valid, busy;
  logic [0:127] in_data, rk_data, out_data;
  logic [3:0]   rk_idx;

  logic [0:127] rks [11];
  logic [7:0]   sbox [256];

  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  aes_inv_round_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk_data(rk_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
`ifdef AES_INV_ROUND_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  assign rk_data = (rk_idx <= 4'd10) ? rks[rk_idx] : '0;

  int unsigned n_cmp = 0, n_bad = 0, n_push = 0, n_xfer = 0;
  int unsigned cyc = 0, acc_cyc = 0, acc_count = 0;
  int unsigned acc_hist[$];
  logic [0:127] exp_q[$];
  bit chk_en = 0, m_busy = 0, od_zero = 1, rand_ready = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cyc %0d: bound expired", nm, cyc);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      xb = x[7:0];
      for (int y = 1; y < 256; y++)
        if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [0:127] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [0:127] aes_enc(input logic [0:127] p);
    logic [7:0] s[16], t[16], u[16];
    logic [0:127] res;
    for (int k = 0; k < 16; k++) s[k] = p[8*k +: 8] ^ rks[0][8*k +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox[s[k]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) u[w+4*c] = t[w+4*((c+w)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(u[4*c],8'h02) ^ gmul(u[4*c+1],8'h03) ^ u[4*c+2] ^ u[4*c+3];
          s[4*c+1] = u[4*c] ^ gmul(u[4*c+1],8'h02) ^ gmul(u[4*c+2],8'h03) ^ u[4*c+3];
          s[4*c+2] = u[4*c] ^ u[4*c+1] ^ gmul(u[4*c+2],8'h02) ^ gmul(u[4*c+3],8'h03);
          s[4*c+3] = gmul(u[4*c],8'h03) ^ u[4*c+1] ^ u[4*c+2] ^ gmul(u[4*c+3],8'h02);
        end
      end else begin
        for (int k = 0; k < 16; k++) s[k] = u[k];
      end
      for (int k = 0; k < 16; k++) s[k] ^= rks[r][8*k +: 8];
    end
    for (int k = 0; k < 16; k++) res[8*k +: 8] = s[k];
    return res;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rand_ready) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: cycle-level model of the handshake plus scoreboard pops on each transfer.
  int unsigned since, exp_rk;
  always @(negedge clk) if (chk_en) begin
    since  = cyc - acc_cyc;
    exp_rk = (m_busy && since >= 1 && since <= 10) ? 10 - since : 10;
    chk("in_ready", in_ready, !m_busy && !rst);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_busy && since >= 11);
    chk("rk_idx", rk_idx, exp_rk);
    if (m_busy && since >= 11) begin
      if (exp_q.size() == 0) fail_now("scoreboard_underflow");
      else chk("out_data", out_data, exp_q[0]);
    end else if (!m_busy && od_zero) begin
      chk("out_data_zero", out_data, '0);
    end
    if (rst) begin
      m_busy = 0; od_zero = 1;
    end else if (abort && m_busy) begin
      m_busy = 0; od_zero = 1;
    end else if (!m_busy && in_valid) begin
      m_busy = 1; od_zero = 0; acc_cyc = cyc;
      acc_hist.push_back(cyc); acc_count++;
    end else if (m_busy && since >= 11 && out_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_busy = 0; n_xfer++;
    end
  end

  task automatic send(input logic [0:127] c, input logic [0:127] p, input bit push, input bit ab);
    int unsigned b;
    if (push) begin exp_q.push_back(p); n_push++; end
    in_data = c; in_valid = 1; abort = ab;
    b = 0;
    while (!in_ready && b < 200) begin @(posedge clk); #1; b++; end
    if (b >= 200) fail_now("accept_timeout");
    @(posedge clk); #1;
    in_valid = 0; abort = 0;
  endtask

  task automatic wait_idle();
    int unsigned b;
    b = 0;
    while ((m_busy || exp_q.size() != 0) && b < 500) begin @(posedge clk); #1; b++; end
    if (b >= 500) fail_now("drain_timeout");
  endtask

  initial begin
    int unsigned n0;
    logic [0:127] p, c, k;
    rst = 1; in_valid = 0; out_ready = 1; abort = 0; in_data = '0;
    build_sbox();
    set_key(C1_KEY);
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;

    send(C1_CT, C1_PT, 1, 0);
    wait_idle();

    out_ready = 0;
    send(C1_CT, C1_PT, 1, 0);
    repeat (30) @(posedge clk);
    #1 out_ready = 1;
    wait_idle();
    @(posedge clk); #1;

    n0 = acc_count;
    exp_q.push_back(C1_PT); exp_q.push_back(C1_PT); exp_q.push_back(C1_PT); n_push += 3;
    in_data = C1_CT; in_valid = 1;
    for (int i = 0; i < 60 && acc_count < n0 + 3; i++) @(posedge clk);
    #1 in_valid = 0;
    if (acc_count < n0 + 3) fail_now("b2b_accepts");
    else begin
      chk("b2b_gap1", acc_hist[n0+1] - acc_hist[n0], 12);
      chk("b2b_gap2", acc_hist[n0+2] - acc_hist[n0+1], 12);
    end
    wait_idle();

    send(128'h0123456789abcdeffedcba9876543210, '0, 0, 0);
    repeat (4) @(posedge clk);
    #1 chk("rk_idx_at_rst", rk_idx, 5);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    send(C1_CT, C1_PT, 1, 0);
    wait_idle();

`ifdef AES_INV_ROUND_CTRL_ABORT_EN
    send(C1_CT, '0, 0, 0);
    repeat (9) @(posedge clk);
    #1 chk("rk_idx_final", rk_idx, 0);
    abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abort_out_data", out_data, '0);
    send(C1_CT, C1_PT, 1, 1);
    wait_idle();
`endif

    send(C1_CT, C1_PT, 1, 0);
    for (int i = 0; i < 9; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 0;
    wait_idle();

    rand_ready = 1;
    for (int i = 0; i < 20; i++) begin
      wait_idle();
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      set_key(k);
      c = aes_enc(p);
      send(c, p, 1, 0);
    end
    wait_idle();
    rand_ready = 0;
    @(posedge clk); #1 out_ready = 1;
    chk("transfers", n_xfer, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative AES-128 decryption round sequencer. It accepts one 128-bit ciphertext block per transaction and runs the 10 inverse rounds, one per cycle, on a single registered state. Each round applies the team's existing Inverse_shiftrow, inv_subbytes and inv_mixcolumns datapath modules in sequence. Round keys are fetched by index from the external key store, and the plaintext is returned over a valid/ready output handshake.

## Interface
- No parameters. AES-128 only: 10 rounds, 128-bit state.
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ciphertext offered
- in_ready  output  1  block can be accepted this cycle
- in_data  input  [0:127]  ciphertext; byte k at bits 8k..8k+7; column-major (bytes 0–3 are column 0)
- rk_idx  output  [3:0]  round-key index requested, 0..10
- rk_data  input  [0:127]  round key for rk_idx; combinational from key store, same cycle, same byte order
- out_valid  output  1  plaintext available
- out_ready  input  1  consumer accepts plaintext
- out_data  output  [0:127]  plaintext; registered, stable while out_valid=1
- busy  output  1  high in any state other than IDLE
- abort  input  1  present only with AES_INV_ROUND_CTRL_ABORT_EN

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. Round counter rnd[3:0].
- IDLE:
  - in_ready=1 and rk_idx=10.
  - On in_valid&&in_ready: state ← in_data ^ rk_data (initial AddRoundKey), rnd ← 9, go to ROUND.
- ROUND:
  - rk_idx=rnd.
  - state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data).
  - If rnd==1, go to FINAL. Otherwise rnd ← rnd−1.
- FINAL:
  - rk_idx=0.
  - state ← InvSubBytes(InvShiftRows(state)) ^ rk_data. No InvMixColumns.
  - Go to DONE.
- DONE:
  - out_valid=1; out_data=state.
  - rk_idx=10 (key store may prefetch).
  - On out_ready, go to IDLE.
- in_ready is low in ROUND, FINAL and DONE. There is no input buffering, and a new block is never accepted in DONE.
- XOR only; no arithmetic beyond the 4-bit down-counter, which never wraps (range 9..1).
- Input or key changes outside the sampling cycle have no effect.

## Timing
- Reset, on the first clk edge with rst=1:
  - FSM=IDLE, rnd=0, state/out_data=0, out_valid=0, busy=0.
  - in_ready is forced 0 while rst=1.
  - rk_idx=10.
- Reset mid-operation (any state): the block is dropped, no out_valid is produced, and the registers above take their reset values on that edge.
- Latency. With acceptance in cycle T:
  - ROUND in cycles T+1..T+9, with rk_idx 9,8,…,1.
  - FINAL in cycle T+10, with rk_idx=0.
  - out_valid first high in cycle T+11.
- Back-to-back: with out_ready tied high, the minimum period is 12 cycles and the next acceptance is at T+12.
- Output backpressure: out_valid and out_data hold indefinitely while out_ready=0.
- Simultaneous rst with any handshake: rst wins.
- rk_data must be valid in the same cycle rk_idx is presented; the key store has zero-cycle latency.

## Configuration
- AES_INV_ROUND_CTRL_ABORT_EN:
  - Defined: the abort port exists. abort=1 in ROUND, FINAL or DONE forces IDLE on the next edge. out_valid drops on that edge, and state/out_data are cleared to 0. abort in IDLE is ignored and does not block acceptance. Reset has priority over abort.
  - Undefined: the port is absent and the FSM has no abort path.

## Test plan
- FIPS-197 C.1 vector:
  - Setup: key 000102030405060708090a0b0c0d0e0f in the bench key-store model; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data=00112233445566778899aabbccddeeff, out_valid first high exactly 11 cycles after acceptance, rk_idx sequence 10,9,…,1,0.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid rises.
  - Required: out_data stable, in_ready=0, busy=1 throughout; a single transfer when out_ready goes high; IDLE on the next cycle.
- Back-to-back:
  - Stimulus: three C.1 blocks with in_valid and out_ready held high.
  - Required: acceptances 12 cycles apart, three identical correct outputs.
- Reset mid-operation:
  - Stimulus: rst pulse in ROUND (rnd=5).
  - Required: out_valid never asserted for that block, all outputs at reset values, in_ready=1 the cycle after rst falls, the next block decrypts correctly.
- Abort (with AES_INV_ROUND_CTRL_ABORT_EN defined):
  - Stimulus: abort in FINAL.
  - Required: IDLE next cycle, no output, out_data=0.
  - Stimulus: abort together with in_valid while in IDLE.
  - Required: the block is accepted.
- Input stability:
  - Stimulus: change in_data and in_valid randomly during ROUND.
  - Required: output is unaffected, equal to C.1 plaintext.
